// File: rtl/dadda_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dadda_div_pkg
//  Description : Shared types and constants for the sequential restoring
//                divider (inverse datapath of the 16x16 Dadda multiplier).
//  Revision    : 1.0 - initial release
// ============================================================================
package dadda_div_pkg;

    // Divisor / quotient / remainder width; the dividend is twice as wide
    localparam int DIV_W = 16;

    // Iteration counter width, wide enough to hold DIV_W itself
    localparam int CNT_W = $clog2(DIV_W + 1);

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage : dadda_div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                {P,Q} pair left by one, then conditionally subtracts the
//                divisor from P and sets the new quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import dadda_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH:0]   w_dv_ext;

    // P stays below the divisor between iterations, so its top bit is free
    // and the shift never loses information.
    assign w_p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
    assign w_q_sh   = {q[WIDTH-2:0], 1'b0};
    assign w_dv_ext = {1'b0, divisor};

    // Trial subtract: keep the difference only when it does not go negative
    always_comb begin
        p_next = w_p_sh;
        q_next = w_q_sh;
        if (w_p_sh >= w_dv_ext) begin
            p_next    = w_p_sh - w_dv_ext;
            q_next[0] = 1'b1;
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/dadda_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : dadda_divider_32
//  Description : Sequential restoring divider, 2*WIDTH-bit dividend by
//                WIDTH-bit divisor, start/busy/done handshake. Divide-by-zero
//                and quotient overflow are detected up front and exit early.
//  Revision    : 1.0 - initial release
// ============================================================================
module dadda_divider_32
    import dadda_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [2*WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     r_p;
    logic [WIDTH-1:0]   r_q;
    logic [C_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_is_zero;
    logic               w_is_ovf;
    logic               w_last;
    logic [WIDTH:0]     w_p_next;
    logic [WIDTH-1:0]   w_q_next;

    // Starts are only honoured when no division is in flight
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_is_zero = (r_divisor == '0);
    // Quotient fits in WIDTH bits only when the high half is below the divisor
    assign w_is_ovf  = (r_dividend[2*WIDTH-1:WIDTH] >= r_divisor);
    assign w_last    = (r_count == C_CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .p       (r_p),
        .q       (r_q),
        .divisor (r_divisor),
        .p_next  (w_p_next),
        .q_next  (w_q_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CHECK;
            CHECK:   w_state_next = (w_is_zero || w_is_ovf) ? DONE : RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? CHECK : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done trails DONE entry by one edge so the pulse stays aligned
            // with results even when a new start is taken in DONE
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_dividend <= dividend;
                r_divisor  <= divisor;
            end
            case (r_state)
                CHECK: begin
                    r_dbz <= 1'b0;
                    r_ovf <= 1'b0;
                    if (w_is_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend[WIDTH-1:0];
                        r_dbz       <= 1'b1;
                    end else if (w_is_ovf) begin
                        r_quotient  <= '1;
                        r_remainder <= '0;
                        r_ovf       <= 1'b1;
                    end else begin
                        r_p     <= {1'b0, r_dividend[2*WIDTH-1:WIDTH]};
                        r_q     <= r_dividend[WIDTH-1:0];
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_p     <= w_p_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + C_CNT_W'(1);
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_p_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == CHECK) || (r_state == RUN);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule : dadda_divider_32
`default_nettype wire

// File: tb/tb_dadda_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dadda_divider_32
//  Description : Self-checking bench for dadda_divider_32: directed corner
//                cases plus randomized operands against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_divider_32;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_checks;
    int n_errors;

    dadda_divider_32 #(
        .WIDTH       (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the error rules layered on top
    task automatic model(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov, output int lat);
        longint quo;
        dz = 1'b0; ov = 1'b0;
        if (dv == 0) begin
            q = '1; r = dd[W-1:0]; dz = 1'b1; lat = 2;
        end else begin
            quo = longint'(dd) / longint'(dv);
            if (quo > 65535) begin
                q = '1; r = '0; ov = 1'b1; lat = 2;
            end else begin
                q = W'(quo); r = W'(longint'(dd) % longint'(dv)); lat = 18;
            end
        end
    endtask

    // Present a start for one edge; returns just after the accepting edge
    task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded
    task automatic wait_done(output int cyc, output logic seen);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        logic [W-1:0] eq, er;
        logic edz, eov;
        int   elat;
        model(dd, dv, eq, er, edz, eov, elat);
        check({tag, "_q"},   64'(quotient),    64'(eq));
        check({tag, "_r"},   64'(remainder),   64'(er));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
        check({tag, "_ovf"}, 64'(overflow),    64'(eov));
    endtask

    task automatic run_op(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        logic [W-1:0] eq, er;
        logic edz, eov, seen;
        int   elat, cyc;
        model(dd, dv, eq, er, edz, eov, elat);
        issue(dd, dv);
        wait_done(cyc, seen);
        check({tag, "_done"}, 64'(seen), 64'(1));
        check({tag, "_lat"},  64'(cyc),  64'(elat));
        check_result(tag, dd, dv);
    endtask

    // Watch a window of cycles and flag any done pulse
    task automatic expect_quiet(input string tag, input int cycles);
        logic any;
        any = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) any = 1'b1;
        end
        check(tag, 64'(any), 64'(0));
    endtask

    initial begin
        logic           seen;
        int             cyc;
        logic [2*W-1:0] rdd;
        logic [W-1:0]   rdv;

        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_q",    64'(quotient), 64'(0));
        check("rst_r",    64'(remainder), 64'(0));
        check("rst_flags", 64'({div_by_zero, overflow}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op("d6_2",      32'd6, 16'd2);
        run_op("d203_20",   32'd203, 16'd20);
        run_op("dmax",      32'hFFFE0001, 16'hFFFF);
        run_op("dzero",     32'd100, 16'd0);
        run_op("dovf",      32'h00010000, 16'd1);
        run_op("dfit",      32'h0000FFFF, 16'd1);

        // Start while busy must be ignored
        issue(32'd75, 16'd5);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid", 64'(busy), 64'(1));
        start = 1'b1; dividend = 32'd9; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, seen);
        check("ign_done", 64'(seen), 64'(1));
        check("ign_lat",  64'(cyc + 4), 64'(18));
        check_result("ign", 32'd75, 16'd5);
        expect_quiet("ign_no_extra_done", 25);

        // Back-to-back: start raised while in DONE (busy low, done not yet)
        issue(32'd1000, 16'd7);
        cyc = 0;
        while (busy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first_lat", 64'(cyc), 64'(17));
        start = 1'b1; dividend = 32'd50000; divisor = 16'd300;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_first_done", 64'(done), 64'(1));
        check_result("b2b_first", 32'd1000, 16'd7);
        check("b2b_busy", 64'(busy), 64'(1));
        wait_done(cyc, seen);
        check("b2b_second_done", 64'(seen), 64'(1));
        check("b2b_second_lat",  64'(cyc), 64'(18));
        check_result("b2b_second", 32'd50000, 16'd300);

        // Reset during RUN aborts with everything cleared
        issue(32'd1000, 16'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_q",    64'(quotient), 64'(0));
        check("abort_r",    64'(remainder), 64'(0));
        check("abort_flags", 64'({div_by_zero, overflow}), 64'(0));
        rst_n = 1'b1;
        expect_quiet("abort_no_done", 25);

        // Randomized operands: mostly legal, with zero and overflow mixed in
        for (int i = 0; i < 1000; i++) begin
            rdv = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rdv = '0;
                1, 2:    rdd = $urandom;
                default: begin
                    if (rdv == 0) rdv = 16'd1;
                    rdd = 32'(rdv) * 32'($urandom_range(0, 65535))
                        + 32'($urandom_range(0, 65535) % rdv);
                end
            endcase
            if (rdv == 0) rdd = $urandom;
            run_op("rnd", rdd, rdv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dadda_divider_32
`default_nettype wire
